// File: rtl/even_seq_checker.sv
// even_seq_checker: checks that the generator produces even values stepping by +2 (mod 16),
// tracks lock/error/wrap status and presents the last value as BCD digits.
// Latency 1 cycle from in_valid (2 cycles for seg outputs); no backpressure, samples every strobe.
// Optional SEG7_EN adds registered 7-segment outputs seg_tens/seg_ones (bit 0 = segment a).
module even_seq_checker #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        in_data,
  input  logic              clr,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [3:0]        last_val,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones
`ifdef SEG7_EN
  ,
  output logic [6:0]        seg_tens,
  output logic [6:0]        seg_ones
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] ref_val;
  logic [3:0] ref_nxt;
  logic [3:0] match_cnt;
  logic [3:0] match_nxt;
  logic       err_nxt;
  logic       wrap_inc;
  logic [3:0] ref_plus2;
  logic       good_step;
  logic       lock_hit;

  // The +2 is a 4-bit add, so 14 steps to 0 naturally.
  assign ref_plus2 = ref_val + 4'd2;
  assign good_step = ~in_data[0] && (in_data == ref_plus2);
  assign lock_hit  = ({1'b0, match_cnt} + 5'd1) == 5'(LOCK_CNT);

  // Next-state, reference and match-count decisions for each accepted sample.
  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_val;
    match_nxt = match_cnt;
    err_nxt   = 1'b0;
    wrap_inc  = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      match_nxt = 4'd0;
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          if (!in_data[0]) begin
            ref_nxt   = in_data;
            match_nxt = 4'd0;
            state_nxt = ACQ;
          end
        end
        ACQ: begin
          if (in_data[0]) begin
            state_nxt = IDLE;
          end else if (good_step) begin
            ref_nxt   = in_data;
            match_nxt = match_cnt + 4'd1;
            if (lock_hit) state_nxt = LOCKED;
          end else begin
            ref_nxt   = in_data;
            match_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (good_step) begin
            ref_nxt  = in_data;
            wrap_inc = (ref_val == 4'd14);
          end else begin
            err_nxt   = 1'b1;
            ref_nxt   = in_data;
            match_nxt = 4'd0;
            state_nxt = in_data[0] ? IDLE : ACQ;
          end
        end
        default: begin
          state_nxt = IDLE;
          match_nxt = 4'd0;
        end
      endcase
    end
  end

  // Sequencing state plus registered lock/error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ref_val   <= 4'd0;
      match_cnt <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      ref_val   <= ref_nxt;
      match_cnt <= match_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_nxt;
    end
  end

  // Saturating error and wrap counters; clr zeroes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else if (clr) begin
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      if (err_nxt && (err_cnt != {ERR_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
      if (wrap_inc && (wrap_cnt != {WRAP_W{1'b1}}))
        wrap_cnt <= wrap_cnt + 1'b1;
    end
  end

  // Last accepted value and its BCD split; clr leaves the display untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val <= 4'd0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
    end else if (in_valid && !clr) begin
      last_val <= in_data;
      if (in_data >= 4'd10) begin
        bcd_tens <= 4'd1;
        bcd_ones <= in_data - 4'd10;
      end else begin
        bcd_tens <= 4'd0;
        bcd_ones <= in_data;
      end
    end
  end

`ifdef SEG7_EN
  function automatic logic [6:0] glyph(input logic [3:0] digit);
    case (digit)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  // Segment patterns follow the BCD registers by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_tens <= 7'b0111111;
      seg_ones <= 7'b0111111;
    end else begin
      seg_tens <= glyph(bcd_tens);
      seg_ones <= glyph(bcd_ones);
    end
  end
`endif

endmodule

// File: tb/tb_even_seq_checker.sv
// tb_even_seq_checker: directed scenarios plus randomized traffic for even_seq_checker.
// Expected values come from an arithmetic reference model of the sequencing rules.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_even_seq_checker;

  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 4;
  localparam int WRAP_W   = 3;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;
  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [3:0]        in_data = 4'd0;
  logic              clr = 1'b0;
  logic              locked;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [3:0]        last_val;
  logic [3:0]        bcd_tens;
  logic [3:0]        bcd_ones;
`ifdef SEG7_EN
  logic [6:0]        seg_tens;
  logic [6:0]        seg_ones;
`endif

  even_seq_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt),
    .last_val(last_val), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
`ifdef SEG7_EN
    , .seg_tens(seg_tens), .seg_ones(seg_ones)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_mode, m_ref, m_streak, m_err, m_wrap, m_last, m_pulse, m_seg_t, m_seg_o;

  // Segment patterns for decimal digits 0..9, bit 0 = segment a.
  int glyph_tbl [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ref = 0; m_streak = 0; m_err = 0; m_wrap = 0;
    m_last = 0; m_pulse = 0; m_seg_t = glyph_tbl[0]; m_seg_o = glyph_tbl[0];
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    bit even, good;
    m_seg_t = glyph_tbl[m_last / 10];
    m_seg_o = glyph_tbl[m_last % 10];
    m_pulse = 0;
    if (c) begin
      m_mode = M_IDLE; m_streak = 0; m_err = 0; m_wrap = 0;
    end else if (v) begin
      m_last = d;
      even = (d % 2) == 0;
      good = even && (d == (m_ref + 2) % 16);
      if (m_mode == M_IDLE) begin
        if (even) begin m_ref = d; m_streak = 0; m_mode = M_ACQ; end
      end else if (m_mode == M_ACQ) begin
        if (!even) m_mode = M_IDLE;
        else if (good) begin
          m_ref = d; m_streak++;
          if (m_streak == LOCK_CNT) m_mode = M_LOCKED;
        end else begin
          m_ref = d; m_streak = 0;
        end
      end else begin
        if (good) begin
          if (m_ref == 14 && d == 0 && m_wrap < WRAP_MAX) m_wrap++;
          m_ref = d;
        end else begin
          m_pulse = 1;
          if (m_err < ERR_MAX) m_err++;
          m_ref = d; m_streak = 0;
          m_mode = even ? M_ACQ : M_IDLE;
        end
      end
    end
  endtask

  task automatic check_all();
    check("locked",    int'(locked),    int'(m_mode == M_LOCKED));
    check("err_pulse", int'(err_pulse), m_pulse);
    check("err_cnt",   int'(err_cnt),   m_err);
    check("wrap_cnt",  int'(wrap_cnt),  m_wrap);
    check("last_val",  int'(last_val),  m_last);
    check("bcd_tens",  int'(bcd_tens),  m_last / 10);
    check("bcd_ones",  int'(bcd_ones),  m_last % 10);
`ifdef SEG7_EN
    check("seg_tens",  int'(seg_tens),  m_seg_t);
    check("seg_ones",  int'(seg_ones),  m_seg_o);
`endif
  endtask

  task automatic step(input bit v, input int d, input bit c);
    in_valid = v; in_data = 4'(d); clr = c;
    @(posedge clk); #1;
    model_step(v, d, c);
    in_valid = 1'b0; clr = 1'b0;
    check_all();
  endtask

  task automatic send(input int d);
    step(1'b1, d, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, d;
    bit v, c;
    model_reset();
    #23;
    check_all();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Acquire lock from a clean start.
    send(0); send(2); send(4);
    check("not_locked_before_6", int'(locked), 0);
    send(6);
    check("locked_after_6", int'(locked), 1);
    check("bcd_ones_6", int'(bcd_ones), 6);

    // Run through a wrap while locked.
    send(8); send(10); send(12);
    check("bcd_tens_12", int'(bcd_tens), 1);
    check("bcd_ones_12", int'(bcd_ones), 2);
    send(14); send(0); send(2);
    check("wrap_once", int'(wrap_cnt), 1);

    // Even sequence error at ref=6, then relock through 14->0 in ACQ.
    send(4); send(6); send(10);
    check("err_pulse_hi", int'(err_pulse), 1);
    step(1'b0, 0, 1'b0);
    check("err_pulse_lo", int'(err_pulse), 0);
    check("err_cnt_1", int'(err_cnt), 1);
    send(12); send(14); send(0);
    check("relocked", int'(locked), 1);
    check("wrap_unchanged", int'(wrap_cnt), 1);

    // Odd value while locked drops to IDLE; 8 restarts acquisition.
    send(5);
    check("err_cnt_2", int'(err_cnt), 2);
    send(8); send(10); send(12); send(14);
    check("relock_from_8", int'(locked), 1);

    // Drive the error counter past saturation.
    for (int i = 0; i < (1 << ERR_W) + 3; i++) begin
      send(1); send(0); send(2); send(4); send(6);
    end
    check("err_sat", int'(err_cnt), ERR_MAX);

    // Drive the wrap counter past saturation.
    for (int i = 0; i < WRAP_MAX + 3; i++) begin
      send(8); send(10); send(12); send(14); send(0); send(2); send(4); send(6);
    end
    check("wrap_sat", int'(wrap_cnt), WRAP_MAX);

    // Clear with a valid sample: counters drop, display holds.
    step(1'b1, 8, 1'b1);
    check("clr_err", int'(err_cnt), 0);
    check("clr_locked", int'(locked), 0);
    check("clr_last_hold", int'(last_val), 6);
    send(10); send(12); send(14);
    check("acq_after_clr", int'(locked), 0);
    send(0);
    check("lock_after_clr", int'(locked), 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      d = (m_ref + 2) % 16;
      else if (r < 8) d = 2 * $urandom_range(0, 7);
      else            d = $urandom_range(0, 15);
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 99) < 2);
      step(v, d, c);
    end

    // Asynchronous reset between edges.
    send((m_ref + 2) % 16);
    send(11);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_last_val", int'(last_val), 0);
`ifdef SEG7_EN
    check("rst_seg_ones", int'(seg_ones), 'h3F);
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all();
    send(0); send(2); send(4); send(6);
    check("lock_after_rst", int'(locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
